// File: rtl/ninja_game_pkg.sv
// Shared grid geometry, FSM encoding and snapshot payload for the ninja game display path.
package ninja_game_pkg;

    localparam int unsigned GRID_ROWS   = 12;
    localparam int unsigned GRID_COLS   = 8;
    localparam int unsigned ROW_W       = 4;
    localparam int unsigned COL_W       = 3;
    localparam int unsigned N_ELEV      = 3;
    localparam int unsigned N_SHUR      = 3;
    localparam int unsigned LEDGE_ROW   = 5;
    localparam int unsigned LAND_ROW_LO = 0;
    localparam int unsigned LAND_ROW_HI = 11;
    localparam int unsigned SHUR_COL    = 2;
    localparam int unsigned ELEV_COL_L  = 3;
    localparam int unsigned ELEV_COL_R  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_BLANK = 2'd3
    } scan_state_t;

    // Coherent copy of the game coordinates held for a whole frame
    typedef struct packed {
        logic [COL_W-1:0]             ninja_x;
        logic [ROW_W-1:0]             ninja_y;
        logic [N_ELEV-1:0][ROW_W-1:0] elev_y;
        logic [N_SHUR-1:0][ROW_W-1:0] shur_y;
    } snap_t;

endpackage

// File: rtl/ninja_matrix_scanner_if.sv
// Game-state inputs and LED matrix outputs of the scanner, grouped as one bundle.
interface ninja_matrix_scanner_if;
    import ninja_game_pkg::*;

    logic                 enable;
    logic                 state_valid;
    logic [COL_W-1:0]     ninja_x;
    logic [ROW_W-1:0]     ninja_y;
    logic [ROW_W-1:0]     elev1_y;
    logic [ROW_W-1:0]     elev2_y;
    logic [ROW_W-1:0]     elev3_y;
    logic [ROW_W-1:0]     shur1_y;
    logic [ROW_W-1:0]     shur2_y;
    logic [ROW_W-1:0]     shur3_y;
    logic [GRID_ROWS-1:0] row_sel;
    logic [GRID_COLS-1:0] col_data;
    logic [ROW_W-1:0]     row_idx;
    logic                 frame_start;

    modport master (
        output enable, state_valid, ninja_x, ninja_y,
               elev1_y, elev2_y, elev3_y, shur1_y, shur2_y, shur3_y,
        input  row_sel, col_data, row_idx, frame_start
    );

    modport slave (
        input  enable, state_valid, ninja_x, ninja_y,
               elev1_y, elev2_y, elev3_y, shur1_y, shur2_y, shur3_y,
        output row_sel, col_data, row_idx, frame_start
    );

endinterface

// File: rtl/ninja_row_compose.sv
// Combinational pixel composer: one grid row of the snapshot to an 8-bit column mask.
module ninja_row_compose
    import ninja_game_pkg::*;
#(
    parameter bit SHOW_TERRAIN = 1'b1
) (
    input  snap_t                snap,
    input  logic [ROW_W-1:0]     row,
    input  logic                 blink_on,
    output logic [GRID_COLS-1:0] cols_c
);

    always_comb begin
        cols_c = '0;
        for (int unsigned i = 0; i < N_SHUR; i++) begin
            if (snap.shur_y[i] == row) cols_c[SHUR_COL] = 1'b1;
        end
        // Elevator is two rows tall; the lower half at row 12 falls off the grid
        for (int unsigned i = 0; i < N_ELEV; i++) begin
            if ((snap.elev_y[i] == row) ||
                ((5'(snap.elev_y[i]) + 5'd1) == 5'(row))) begin
                cols_c[ELEV_COL_L] = 1'b1;
                cols_c[ELEV_COL_R] = 1'b1;
            end
        end
        if (SHOW_TERRAIN) begin
            if (row == ROW_W'(LEDGE_ROW)) cols_c[2:0] = '1;
            if ((row == ROW_W'(LAND_ROW_LO)) || (row == ROW_W'(LAND_ROW_HI))) cols_c[7:5] = '1;
        end
        // Ninja overrides everything at its cell: lit or punched dark by blink phase
        if (snap.ninja_y == row) cols_c[snap.ninja_x] = blink_on;
    end

endmodule

// File: rtl/ninja_matrix_scanner.sv
// Row-multiplexed 12x8 LED matrix scanner with per-frame snapshot of the ninja game state.
module ninja_matrix_scanner
    import ninja_game_pkg::*;
#(
    parameter int unsigned ROW_DWELL    = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 8,
    parameter bit          SHOW_TERRAIN = 1'b1
) (
    input  logic               clk_input,
    input  logic               reset,
    ninja_matrix_scanner_if.slave bus
);

    localparam int unsigned DWELL_W = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);

    scan_state_t          state_q, state_next;
    logic [ROW_W-1:0]     row_idx_q, row_idx_next;
    logic [DWELL_W-1:0]   dwell_q, dwell_next;
    logic [BLANK_W-1:0]   blank_q, blank_next;
    logic [FRAME_W-1:0]   frame_cnt_q, frame_cnt_next;
    logic                 phase_q, phase_next;
    snap_t                snap_q, snap_next;
    logic [GRID_ROWS-1:0] row_sel_q, row_sel_next;
    logic [GRID_COLS-1:0] col_data_q, col_data_next;
    logic                 frame_start_q, frame_start_next;
    logic [GRID_COLS-1:0] cols_next_c;

    // Composed from next-cycle values so the first SHOW cycle already carries valid data
    ninja_row_compose #(
        .SHOW_TERRAIN (SHOW_TERRAIN)
    ) u_compose (
        .snap     (snap_next),
        .row      (row_idx_next),
        .blink_on (phase_next),
        .cols_c   (cols_next_c)
    );

    always_ff @(posedge clk_input or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            row_idx_q     <= '0;
            dwell_q       <= '0;
            blank_q       <= '0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b1;
            snap_q        <= '0;
            row_sel_q     <= '0;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_next;
            row_idx_q     <= row_idx_next;
            dwell_q       <= dwell_next;
            blank_q       <= blank_next;
            frame_cnt_q   <= frame_cnt_next;
            phase_q       <= phase_next;
            snap_q        <= snap_next;
            row_sel_q     <= row_sel_next;
            col_data_q    <= col_data_next;
            frame_start_q <= frame_start_next;
        end
    end

    always_comb begin
        state_next     = state_q;
        row_idx_next   = row_idx_q;
        dwell_next     = dwell_q;
        blank_next     = blank_q;
        frame_cnt_next = frame_cnt_q;
        phase_next     = phase_q;
        snap_next      = snap_q;

        if (!bus.enable) begin
            // Dropping enable abandons the frame; snapshot and blink phase survive
            state_next     = ST_IDLE;
            row_idx_next   = '0;
            dwell_next     = '0;
            blank_next     = '0;
            frame_cnt_next = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_next = ST_LOAD;
                end
                ST_LOAD: begin
                    state_next   = ST_SHOW;
                    row_idx_next = '0;
                    if (bus.state_valid) begin
                        snap_next.ninja_x   = bus.ninja_x;
                        snap_next.ninja_y   = bus.ninja_y;
                        snap_next.elev_y[0] = bus.elev1_y;
                        snap_next.elev_y[1] = bus.elev2_y;
                        snap_next.elev_y[2] = bus.elev3_y;
                        snap_next.shur_y[0] = bus.shur1_y;
                        snap_next.shur_y[1] = bus.shur2_y;
                        snap_next.shur_y[2] = bus.shur3_y;
                    end
                    // Frame count already at BLINK_FRAMES means this LOAD closes a half-period
                    if (frame_cnt_q == FRAME_W'(BLINK_FRAMES)) begin
                        phase_next     = ~phase_q;
                        frame_cnt_next = FRAME_W'(1);
                    end else begin
                        frame_cnt_next = frame_cnt_q + FRAME_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (dwell_q == DWELL_W'(ROW_DWELL - 1)) begin
                        state_next = ST_BLANK;
                        dwell_next = '0;
                    end else begin
                        dwell_next = dwell_q + DWELL_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (blank_q == BLANK_W'(BLANK_CYCLES - 1)) begin
                        blank_next = '0;
                        if (row_idx_q == ROW_W'(GRID_ROWS - 1)) begin
                            state_next   = ST_LOAD;
                            row_idx_next = '0;
                        end else begin
                            state_next   = ST_SHOW;
                            row_idx_next = row_idx_q + ROW_W'(1);
                        end
                    end else begin
                        blank_next = blank_q + BLANK_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        row_sel_next     = (state_next == ST_SHOW) ? (GRID_ROWS'(1) << row_idx_next) : '0;
        col_data_next    = (state_next == ST_SHOW) ? cols_next_c : '0;
        frame_start_next = (state_next == ST_LOAD);
    end

    assign bus.row_sel     = row_sel_q;
    assign bus.col_data    = col_data_q;
    assign bus.row_idx     = row_idx_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_ninja_matrix_scanner.sv
// Directed bench for ninja_matrix_scanner: row scoreboard filled at each LOAD plus timing and blink checks.
module tb_ninja_matrix_scanner;

    localparam int unsigned ROW_DWELL    = 4;
    localparam int unsigned BLANK_CYCLES = 2;
    localparam int unsigned BLINK_FRAMES = 2;

    typedef struct {
        int         row;
        logic [7:0] cols;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ninja_matrix_scanner_if bus ();

    ninja_matrix_scanner #(
        .ROW_DWELL    (ROW_DWELL),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES),
        .SHOW_TERRAIN (1'b1)
    ) dut (
        .clk_input (clk),
        .reset     (rst_n),
        .bus       (bus.slave)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    exp_t       sb[$];
    bit         sb_on = 1'b0;
    logic [11:0] prev_row_sel = '0;

    // Reference model of the displayed snapshot and blink state
    logic m_phase = 1'b1;
    int   m_fcnt  = 0;
    int   m_nx = 0, m_ny = 0;
    int   m_ey[3] = '{0, 0, 0};
    int   m_sy[3] = '{0, 0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_cols(input int r);
        logic [7:0] v;
        bit on;
        v = '0;
        for (int c = 0; c < 8; c++) begin
            on = 1'b0;
            if (c == 2)
                for (int i = 0; i < 3; i++) if (m_sy[i] == r) on = 1'b1;
            if (c == 3 || c == 4)
                for (int i = 0; i < 3; i++) if (m_ey[i] == r || m_ey[i] + 1 == r) on = 1'b1;
            if (r == 5 && c <= 2) on = 1'b1;
            if ((r == 0 || r == 11) && c >= 5) on = 1'b1;
            if (m_ny == r && m_nx == c) on = m_phase;
            v[c] = on;
        end
        return v;
    endfunction

    task automatic model_load();
        exp_t e;
        if (bus.state_valid) begin
            m_nx = int'(bus.ninja_x);  m_ny = int'(bus.ninja_y);
            m_ey[0] = int'(bus.elev1_y); m_ey[1] = int'(bus.elev2_y); m_ey[2] = int'(bus.elev3_y);
            m_sy[0] = int'(bus.shur1_y); m_sy[1] = int'(bus.shur2_y); m_sy[2] = int'(bus.shur3_y);
        end
        if (m_fcnt == int'(BLINK_FRAMES)) begin
            m_phase = ~m_phase;
            m_fcnt  = 1;
        end else begin
            m_fcnt++;
        end
        for (int r = 0; r < 12; r++) begin
            e.row  = r;
            e.cols = exp_cols(r);
            sb.push_back(e);
        end
    endtask

    // Scoreboard: expectations pushed at LOAD, popped on the first cycle of each lit row
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && bus.frame_start === 1'b1) model_load();
        if (sb_on && bus.row_sel !== 12'h000 && prev_row_sel === 12'h000) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("sb_row_sel", 32'(bus.row_sel), 32'(12'(1) << e.row));
                check("sb_row_idx", 32'(bus.row_idx), 32'(e.row));
                check("sb_cols", 32'(bus.col_data), 32'(e.cols));
            end
        end
        prev_row_sel = bus.row_sel;
    end

    task automatic set_inputs(input int nx, input int ny, input int e1, input int e2,
                              input int e3, input int s1, input int s2, input int s3);
        bus.ninja_x = 3'(nx); bus.ninja_y = 4'(ny);
        bus.elev1_y = 4'(e1); bus.elev2_y = 4'(e2); bus.elev3_y = 4'(e3);
        bus.shur1_y = 4'(s1); bus.shur2_y = 4'(s2); bus.shur3_y = 4'(s3);
    endtask

    task automatic sample_row(input int r, input logic [7:0] exp, input string tag);
        logic [11:0] oh;
        bit found;
        oh = 12'(1) << r;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (bus.row_sel === oh) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) check(tag, 32'(bus.col_data), 32'(exp));
    endtask

    task automatic wait_frame_start(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_sel;
        int r, w;

        rst_n = 1'b0;
        bus.enable = 1'b0;
        bus.state_valid = 1'b1;
        set_inputs(6, 0, 2, 6, 10, 8, 5, 2);

        repeat (2) @(negedge clk);
        check("rst_row_sel", 32'(bus.row_sel), 32'h0);
        check("rst_col_data", 32'(bus.col_data), 32'h0);
        check("rst_row_idx", 32'(bus.row_idx), 32'h0);
        check("rst_frame_start", 32'(bus.frame_start), 32'h0);

        // Start scanning, then pull reset in the middle of row 0
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_row_sel", 32'(bus.row_sel), 32'h001);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_row_sel", 32'(bus.row_sel), 32'h0);
        check("async_rst_col_data", 32'(bus.col_data), 32'h0);
        check("async_rst_frame_start", 32'(bus.frame_start), 32'h0);
        @(posedge clk); #1;
        m_phase = 1'b1; m_fcnt = 0;
        m_nx = 0; m_ny = 0; m_ey = '{0, 0, 0}; m_sy = '{0, 0, 0};
        sb.delete();
        sb_on = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("restart_load_pulse", 32'(bus.frame_start), 32'h1);
        check("restart_load_dark", 32'(bus.row_sel), 32'h0);

        // Frame 1: reference pattern
        sample_row(0, 8'hE0, "f1_row0");
        sample_row(2, 8'h1C, "f1_row2");
        sample_row(3, 8'h18, "f1_row3");
        sample_row(5, 8'h07, "f1_row5");
        sample_row(8, 8'h04, "f1_row8");
        sample_row(11, 8'hF8, "f1_row11");

        // Frame 2: cycle-exact row/blank sequence and frame period
        wait_frame_start("f2_start");
        for (int k = 1; k <= 72; k++) begin
            @(negedge clk);
            r = (k - 1) / 6;
            w = (k - 1) % 6;
            exp_sel = (w < 4) ? (12'(1) << r) : 12'h000;
            check("timing_row_sel", 32'(bus.row_sel), 32'(exp_sel));
            check("timing_no_pulse", 32'(bus.frame_start), 32'h0);
        end
        @(negedge clk);
        check("timing_period_73", 32'(bus.frame_start), 32'h1);

        // Frame 3: blink off; inputs change mid-frame with valid low
        sample_row(0, 8'hA0, "f3_blink_off_row0");
        sample_row(5, 8'h07, "f3_row5");
        @(posedge clk); #1;
        set_inputs(1, 7, 11, 3, 15, 13, 9, 0);
        bus.state_valid = 1'b0;
        sample_row(8, 8'h04, "f3_hold_row8");
        sample_row(11, 8'hF8, "f3_hold_row11");

        // Frame 4: previous snapshot reused, still blinking off
        wait_frame_start("f4_start");
        sample_row(0, 8'hA0, "f4_blink_off_row0");
        sample_row(2, 8'h1C, "f4_reuse_row2");
        @(posedge clk); #1;
        bus.state_valid = 1'b1;

        // Frame 5: new snapshot, elevator at row 11 and out-of-range shuriken
        wait_frame_start("f5_start");
        sample_row(0, 8'hE4, "f5_elev_nowrap_row0");
        sample_row(4, 8'h18, "f5_row4");

        // Drop enable for 10 clocks in the middle of row 4
        @(posedge clk); #1;
        bus.enable = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("dark_row_sel", 32'(bus.row_sel), 32'h0);
            check("dark_col_data", 32'(bus.col_data), 32'h0);
            check("dark_frame_start", 32'(bus.frame_start), 32'h0);
        end
        check("dark_row_idx", 32'(bus.row_idx), 32'h0);
        sb.delete();
        m_fcnt = 0;
        @(posedge clk); #1;
        bus.enable = 1'b1;
        repeat (2) @(negedge clk);
        check("reenable_load", 32'(bus.frame_start), 32'h1);
        @(negedge clk);
        check("reenable_row0_sel", 32'(bus.row_sel), 32'h001);
        check("reenable_row0_idx", 32'(bus.row_idx), 32'h0);
        sample_row(7, 8'h02, "f6_ninja_row7");
        sample_row(11, 8'hF8, "f6_elev11_row11");

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
